// File: rtl/friscv_inst_prefetch_if.sv
// Core fetch port and instruction RAM port of the prefetcher, bundled as one interface.
// master: the prefetcher side; slave: the core/RAM environment side.
interface friscv_inst_prefetch_if #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 16
);
    logic             cpu_en;
    logic [ADDRW-1:0] cpu_addr;
    logic [XLEN-1:0]  cpu_rdata;
    logic             cpu_ready;
    logic             mem_en;
    logic [ADDRW-1:0] mem_addr;
    logic [XLEN-1:0]  mem_rdata;

    modport master (
        input  cpu_en, cpu_addr, mem_rdata,
        output cpu_rdata, cpu_ready, mem_en, mem_addr
    );

    modport slave (
        output cpu_en, cpu_addr, mem_rdata,
        input  cpu_rdata, cpu_ready, mem_en, mem_addr
    );
endinterface

// File: rtl/friscv_inst_prefetch.sv
// Sequential instruction prefetcher: a DEPTH-word FIFO streamed from a 1-cycle-latency RAM.
// Define PREFETCH_BYPASS_EN to forward the in-flight RAM word on a miss (one cycle less latency).
module friscv_inst_prefetch #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 16,
    parameter int DEPTH = 4
) (
    input logic                    aclk,
    input logic                    srst,
    friscv_inst_prefetch_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_nxt;
    logic [XLEN-1:0]  fifo [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, occ;
    logic             pending;
    logic [ADDRW-1:0] head_addr, fetch_addr;
    logic [XLEN-1:0]  last_rdata, rdata_now;
    logic             hit, miss, bypass, issue, push, addr_match;

    assign occ        = count + CW'(pending);
    assign addr_match = (bus.cpu_addr == head_addr);

    always_ff @(posedge aclk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    // With an empty FIFO, head_addr names the word still on its way, so a
    // request for it waits instead of re-missing.
    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        miss      = 1'b0;
        bypass    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_en) begin
                    miss      = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (bus.cpu_en && addr_match && count != '0) hit = 1'b1;
`ifdef PREFETCH_BYPASS_EN
                else if (bus.cpu_en && addr_match && pending) bypass = 1'b1;
`endif
                else if (bus.cpu_en && !addr_match) miss = 1'b1;
                issue = !miss && (occ < CW'(DEPTH));
            end
            default: state_nxt = IDLE;
        endcase
        if (srst) begin
            state_nxt = IDLE;
            hit       = 1'b0;
            miss      = 1'b0;
            bypass    = 1'b0;
            issue     = 1'b0;
        end
    end

    // A response arriving in a miss cycle belongs to the flushed stream and is dropped.
    assign push = pending && !miss && !bypass && !srst;

`ifdef PREFETCH_BYPASS_EN
    assign rdata_now = bypass ? bus.mem_rdata : fifo[rd_ptr];
`else
    assign rdata_now = fifo[rd_ptr];
`endif

    assign bus.cpu_ready = hit | bypass;
    assign bus.cpu_rdata = srst ? '0 : (bus.cpu_ready ? rdata_now : last_rdata);
    assign bus.mem_en    = issue;
    assign bus.mem_addr  = srst ? '0 : fetch_addr;

    always_ff @(posedge aclk) begin
        if (push) fifo[wr_ptr] <= bus.mem_rdata;
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pending    <= 1'b0;
            head_addr  <= '0;
            fetch_addr <= '0;
            last_rdata <= '0;
        end else begin
            pending <= issue;
            if (bus.cpu_ready) last_rdata <= rdata_now;
            if (miss) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                head_addr  <= bus.cpu_addr;
                fetch_addr <= bus.cpu_addr;
            end else begin
                if (issue)        fetch_addr <= fetch_addr + ADDRW'(4);
                if (push)         wr_ptr     <= wr_ptr + PW'(1);
                if (hit)          rd_ptr     <= rd_ptr + PW'(1);
                if (hit | bypass) head_addr  <= head_addr + ADDRW'(4);
                count <= count + CW'(push) - CW'(hit);
            end
        end
    end

endmodule

// File: tb/tb_friscv_inst_prefetch.sv
// Directed bench for friscv_inst_prefetch: vector table for cold start/streaming, hand sequences
// for branch, backpressure, address wrap and mid-operation reset.
module tb_friscv_inst_prefetch;

    localparam int XLEN  = 32;
    localparam int ADDRW = 16;
    localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif
    localparam int NV = LAT + 16;

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic        rdy;
        logic [31:0] rdata;
        logic        men;
        logic [15:0] maddr;
    } vec_t;

    logic aclk = 1'b0;
    logic srst;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs [NV];
    logic [15:0] issued [$];

    always #5 aclk = ~aclk;

    friscv_inst_prefetch_if #(.XLEN(XLEN), .ADDRW(ADDRW)) bus ();

    friscv_inst_prefetch #(.XLEN(XLEN), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .aclk (aclk),
        .srst (srst),
        .bus  (bus)
    );

    function automatic logic [31:0] ram(input logic [15:0] a);
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    // RAM model: one-cycle read latency, junk when not read.
    always @(posedge aclk) begin
        if (bus.mem_en) bus.mem_rdata <= ram(bus.mem_addr);
        else            bus.mem_rdata <= 32'hDEAD_BEEF;
    end

    always @(negedge aclk) begin
        if (bus.mem_en && !srst) issued.push_back(bus.mem_addr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step(input logic rst, input logic en, input logic [15:0] a);
        @(posedge aclk);
        #1;
        srst         = rst;
        bus.cpu_en   = en;
        bus.cpu_addr = a;
        @(negedge aclk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
    endtask

    task automatic fetch(input logic [15:0] a, input int lat, input string name);
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b1, a);
            n++;
        end while (!bus.cpu_ready && n < 8);
        check({name, " latency"}, n, lat);
        check({name, " rdata"}, bus.cpu_rdata, ram(a));
    endtask

    initial begin
        srst          = 1'b1;
        bus.cpu_en    = 1'b0;
        bus.cpu_addr  = '0;

        for (int j = 0; j < LAT; j++) begin
            vecs[j] = '{en: 1'b1, addr: 16'h0, rdy: 1'b0, rdata: 32'h0,
                        men: (j >= 1), maddr: 16'(4 * (j - 1))};
        end
        for (int i = 0; i < 16; i++) begin
            vecs[LAT + i] = '{en: 1'b1, addr: 16'(4 * i), rdy: 1'b1, rdata: ram(16'(4 * i)),
                              men: 1'b1, maddr: 16'(4 * i + 4 * (LAT - 1))};
        end

        // Reset state
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h40);
        check("rst cpu_ready", bus.cpu_ready, 0);
        check("rst cpu_rdata", bus.cpu_rdata, 0);
        check("rst mem_en", bus.mem_en, 0);
        check("rst mem_addr", bus.mem_addr, 0);

        // Cold start and streaming from 0x0000
        for (int i = 0; i < NV; i++) begin
            step(1'b0, vecs[i].en, vecs[i].addr);
            check($sformatf("row%0d cpu_ready", i), bus.cpu_ready, vecs[i].rdy);
            check($sformatf("row%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].rdata);
            check($sformatf("row%0d mem_en", i), bus.mem_en, vecs[i].men);
            if (vecs[i].men)
                check($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].maddr);
        end

        // Branch while streaming
        do_reset();
        fetch(16'h0000, LAT + 1, "br 0x0");
        fetch(16'h0004, 1, "br 0x4");
        fetch(16'h0008, 1, "br 0x8");
        fetch(16'h000C, 1, "br 0xC");
        fetch(16'h0010, 1, "br 0x10");
        step(1'b0, 1'b1, 16'h0100);
        check("br miss ready", bus.cpu_ready, 0);
        check("br miss rdata hold", bus.cpu_rdata, ram(16'h0010));
        check("br miss mem_en", bus.mem_en, 0);
        step(1'b0, 1'b1, 16'h0100);
        check("br N+1 ready", bus.cpu_ready, 0);
        check("br N+1 mem_en", bus.mem_en, 1);
        check("br N+1 mem_addr", bus.mem_addr, 32'h0100);
        fetch(16'h0100, LAT - 1, "br 0x100");
        fetch(16'h0104, 1, "br 0x104");

        // Backpressure: exactly DEPTH reads, then resume without refetch
        do_reset();
        step(1'b0, 1'b1, 16'h0200);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0);
            check($sformatf("bp%0d cpu_ready", i), bus.cpu_ready, 0);
            check($sformatf("bp%0d mem_en", i), bus.mem_en, (i < DEPTH));
            if (i < DEPTH)
                check($sformatf("bp%0d mem_addr", i), bus.mem_addr, 32'h0200 + 32'(4 * i));
        end
        fetch(16'h0200, 1, "bp 0x200");
        check("bp full mem_en", bus.mem_en, 0);
        fetch(16'h0204, 1, "bp 0x204");
        check("bp refill mem_en", bus.mem_en, 1);
        check("bp refill mem_addr", bus.mem_addr, 32'h0210);
        fetch(16'h0208, 1, "bp 0x208");
        fetch(16'h020C, 1, "bp 0x20C");

        // Address wrap
        do_reset();
        issued.delete();
        fetch(16'hFFF8, LAT + 1, "wrap 0xFFF8");
        fetch(16'hFFFC, 1, "wrap 0xFFFC");
        fetch(16'h0000, 1, "wrap 0x0000");
        fetch(16'h0004, 1, "wrap 0x0004");
        check("wrap issue count", (issued.size() >= 3), 1);
        if (issued.size() >= 3) begin
            check("wrap issue0", issued[0], 32'hFFF8);
            check("wrap issue1", issued[1], 32'hFFFC);
            check("wrap issue2", issued[2], 32'h0000);
        end
        step(1'b0, 1'b0, 16'h0);
        check("idle cpu_ready", bus.cpu_ready, 0);
        check("idle rdata hold", bus.cpu_rdata, ram(16'h0004));

        // Reset the cycle after a read is issued
        do_reset();
        step(1'b0, 1'b1, 16'h0040);
        step(1'b0, 1'b1, 16'h0040);
        check("mid mem_en", bus.mem_en, 1);
        check("mid mem_addr", bus.mem_addr, 32'h0040);
        step(1'b1, 1'b0, 16'h0);
        check("mid rst ready", bus.cpu_ready, 0);
        check("mid rst rdata", bus.cpu_rdata, 0);
        check("mid rst mem_en", bus.mem_en, 0);
        check("mid rst mem_addr", bus.mem_addr, 0);
        fetch(16'h0020, LAT + 1, "mid 0x20");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
